// File: rtl/vec3_normalize.sv
// vec3_normalize: normalises a signed Q8.24 3-vector using an external inv_sqrt unit
// and one shared multiplier, with valid/ready handshakes on both sides.
module vec3_normalize #(
  parameter int WIDTH       = 32,
  parameter int ISQ_LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  output logic [WIDTH-1:0] isq_x,
  input  logic [WIDTH-1:0] isq_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero
);
  localparam int FRAC = 24;
  localparam int P    = 2 * WIDTH;
  localparam logic [WIDTH+2:0] TERM_MAX = {3'b001, {WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, SQ, WAIT, SCALE, DONE} state_t;
  state_t                  st;
  logic signed [WIDTH-1:0] xr, yr, zr;
  logic [1:0]              idx;
  logic [7:0]              cnt;
  logic [WIDTH+2:0]        acc, nacc;
  logic [WIDTH-1:0]        inv, isq_sat, out_sat;
  logic signed [P-1:0]     a, b, sh;
  logic                    fits;
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  // One multiplier: c*c while summing squares, c*inv while scaling.
  always_comb begin
    a       = P'(idx == 2'd0 ? xr : idx == 2'd1 ? yr : zr);
    b       = st == SQ ? a : P'(inv);
    sh      = (a * b) >>> FRAC;
    // A single square above 32 bits already forces saturation, so clamp it to keep acc small.
    nacc    = acc + (|sh[P-1:WIDTH] ? TERM_MAX : {3'b000, sh[WIDTH-1:0]});
    isq_sat = |nacc[WIDTH+2:WIDTH] ? '1 : nacc[WIDTH-1:0];
    fits    = &sh[P-1:WIDTH-1] | ~|sh[P-1:WIDTH-1];
    out_sat = fits ? sh[WIDTH-1:0] : sh[P-1] ? MINV : MAXV;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st       <= IDLE;
      xr       <= '0;
      yr       <= '0;
      zr       <= '0;
      idx      <= '0;
      cnt      <= '0;
      acc      <= '0;
      inv      <= '0;
      isq_x    <= '0;
      out_x    <= '0;
      out_y    <= '0;
      out_z    <= '0;
      out_zero <= 1'b0;
    end else
      case (st)
        IDLE: if (in_valid) begin
          xr  <= in_x;
          yr  <= in_y;
          zr  <= in_z;
          acc <= '0;
          idx <= '0;
          st  <= SQ;
        end
        SQ: begin
          acc <= nacc;
          idx <= idx + 2'd1;
          if (idx == 2'd2) begin
            isq_x <= isq_sat;
            idx   <= '0;
            cnt   <= '0;
            if (nacc == '0) begin
              out_x    <= '0;
              out_y    <= '0;
              out_z    <= '0;
              out_zero <= 1'b1;
              st       <= DONE;
            end else st <= WAIT;
          end
        end
        // Waiting one edge beyond the unit latency makes its internal phase irrelevant.
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'(ISQ_LATENCY)) begin
            inv <= isq_result;
            st  <= SCALE;
          end
        end
        SCALE: begin
          idx   <= idx + 2'd1;
          out_x <= idx == 2'd0 ? out_sat : out_x;
          out_y <= idx == 2'd1 ? out_sat : out_y;
          out_z <= idx == 2'd2 ? out_sat : out_z;
          if (idx == 2'd2) begin
            idx      <= '0;
            out_zero <= 1'b0;
            st       <= DONE;
          end
        end
        DONE: if (out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
endmodule

// File: tb/tb_vec3_normalize.sv
// tb_vec3_normalize: directed and random vectors against a plain-arithmetic model,
// with a latency-accurate inv_sqrt stub.
module tb_vec3_normalize;
  localparam int L = 3;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_zero;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic [31:0] isq_x, isq_result, out_x, out_y, out_z;
  logic [31:0] p0, p1, p2;
  logic        force_inv = 1'b0;
  logic [31:0] stub_val = '0;
  int          tests = 0, fails = 0;
  always #5 clk = ~clk;
  vec3_normalize #(.WIDTH(32), .ISQ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .isq_x(isq_x), .isq_result(isq_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
    .out_z(out_z), .out_zero(out_zero)
  );
  function automatic logic [31:0] inv_f(input logic [31:0] s);
    real    r;
    longint q;
    if (s == 0) return 32'hFFFFFFFF;
    r = 68719476736.0 / $sqrt(real'(s));
    if (r >= 4294967295.0) return 32'hFFFFFFFF;
    q = longint'(r);
    return q[31:0];
  endfunction
  // Stub result only becomes valid L edges after isq_x changes; garbage before that.
  always @(posedge clk) begin
    p0 <= isq_x;
    p1 <= p0;
    p2 <= p1;
  end
  assign isq_result = (p2 === isq_x) ? (force_inv ? stub_val : inv_f(isq_x)) : 32'hDEADBEEF;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model(input logic [31:0] x, y, z, output logic [31:0] ex, ey, ez, es,
                       output logic ezero);
    longint      c[3], s, q;
    logic [31:0] inv, r[3];
    c = '{longint'($signed(x)), longint'($signed(y)), longint'($signed(z))};
    s = 0;
    foreach (c[i]) s += (c[i] * c[i]) >>> 24;
    es    = s > 64'sh0FFFFFFFF ? 32'hFFFFFFFF : s[31:0];
    ezero = s == 0;
    inv   = force_inv ? stub_val : inv_f(es);
    foreach (c[i]) begin
      q    = (c[i] * longint'(inv)) >>> 24;
      r[i] = q > 64'sh7FFFFFFF ? 32'h7FFFFFFF : q < -64'sh80000000 ? 32'h80000000 : q[31:0];
    end
    ex = ezero ? 32'h0 : r[0];
    ey = ezero ? 32'h0 : r[1];
    ez = ezero ? 32'h0 : r[2];
  endtask
  task automatic run_vec(input logic [31:0] x, y, z, input int hold);
    logic [31:0] ex, ey, ez, es;
    logic        ezero;
    int          n;
    model(x, y, z, ex, ey, ez, es, ezero);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), ezero ? 32'd3 : 32'(7 + L));
    check("isq_x", isq_x, es);
    check("out_x", out_x, ex);
    check("out_y", out_y, ey);
    check("out_z", out_z, ez);
    check("out_zero", 32'(out_zero), 32'(ezero));
    repeat (hold) begin
      in_valid = 1'b1;
      in_x = ~x;
      @(negedge clk);
      in_valid = 1'b0;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_x", out_x, ex);
      check("hold_y", out_y, ey);
      check("hold_zero", 32'(out_zero), 32'(ezero));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_ready", 32'(in_ready), 32'd1);
    check("post_keep_x", out_x, ex);
  endtask
  initial begin
    logic [31:0] v[3], m;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_isq_x", isq_x, 32'd0);
    check("rst_out_x", out_x, 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    force_inv = 1'b1;
    stub_val = 32'h01000000; run_vec(32'h01000000, 32'h0, 32'h0, 0);
    stub_val = 32'h00333333; run_vec(32'h03000000, 32'h04000000, 32'h0, 0);
    stub_val = 32'h00800000; run_vec(32'hFE000000, 32'h0, 32'h0, 0);
    stub_val = 32'h12345678; run_vec(32'h0, 32'h0, 32'h0, 0);
    stub_val = 32'h00100000; run_vec(32'h10000000, 32'h10000000, 32'h0, 0);
    stub_val = 32'h7FFFFFFF; run_vec(32'h10000000, 32'h0, 32'h0, 0);
    stub_val = 32'h7FFFFFFF; run_vec(32'hF0000000, 32'h0, 32'h0, 0);
    stub_val = 32'h01000000; run_vec(32'h00000800, 32'hFFFFF800, 32'h0, 0);
    stub_val = 32'h00333333; run_vec(32'h03000000, 32'h04000000, 32'h0, 5);
    run_vec(32'h0, 32'h0, 32'h0, 2);
    // Reset in the middle of WAIT must discard everything at once.
    stub_val = 32'h01000000;
    @(negedge clk);
    in_x = 32'h02000000; in_y = 32'h01000000; in_z = 32'h0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_isq_x", isq_x, 32'd0);
    check("mid_rst_out_x", out_x, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    force_inv = 1'b0;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 3; i++) begin
        m    = t % 4 == 3 ? $urandom : $urandom_range(0, 32'h0800_0000);
        v[i] = $urandom_range(0, 1) ? -m : m;
      end
      run_vec(v[0], v[1], v[2], t % 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
